// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-port memory arbiter.
// Memory is byte addressed; each access moves one big-endian 16-bit word.
package mem_port_arbiter_pkg;

    localparam int MEM_DEPTH  = 1024;
    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int LEN_WIDTH  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: with both requesters valid, the one that did
// not win last time is chosen. Purely combinational.
module mem_port_arbiter_rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_rr_last,
    output logic o_win,
    output logic o_any
);

    // Winner select and any-request flag.
    always_comb begin
        o_any = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_win = ~i_rr_last;
        end else if (i_valid1) begin
            o_win = 1'b1;
        end else begin
            o_win = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressed 16-bit-word memory between two
// burst requesters. Bursts of 1..16 beats at ascending, wrapping word addresses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req0_valid,
    input  logic                  i_req0_wr,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [LEN_WIDTH-1:0]  i_req0_len,
    input  logic [WORD_WIDTH-1:0] i_req0_wdata,
    output logic                  o_req0_grant,
    output logic                  o_req0_beat,
    output logic                  o_req0_done,
    output logic                  o_req0_err,
    input  logic                  i_req1_valid,
    input  logic                  i_req1_wr,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [LEN_WIDTH-1:0]  i_req1_len,
    input  logic [WORD_WIDTH-1:0] i_req1_wdata,
    output logic                  o_req1_grant,
    output logic                  o_req1_beat,
    output logic                  o_req1_done,
    output logic                  o_req1_err,
    output logic                  o_rd_valid,
    output logic                  o_rd_id,
    output logic [WORD_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic                  o_mem_wr_en,
    output logic [WORD_WIDTH-1:0] o_mem_data_in,
    input  logic [WORD_WIDTH-1:0] i_mem_data_out
);

    localparam logic [ADDR_WIDTH-1:0] REJECT_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LAST_WORD   = (ADDR_WIDTH + 1)'(MEM_DEPTH - 2);
    localparam logic [ADDR_WIDTH:0]   ADDR_STEP   = (ADDR_WIDTH + 1)'(2);
    localparam logic [LEN_WIDTH:0]    MAX_BEATS   = (LEN_WIDTH + 1)'(2 ** LEN_WIDTH);
    localparam logic [LEN_WIDTH:0]    ONE_BEAT    = (LEN_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO   = {ADDR_WIDTH{1'b0}};
    localparam logic [WORD_WIDTH-1:0] WORD_ZERO   = {WORD_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO    = {LEN_WIDTH{1'b0}};

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic                    r_win;
    logic                    w_win_next;
    logic                    r_wr;
    logic                    w_wr_next;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [LEN_WIDTH:0]      r_remain;
    logic [LEN_WIDTH:0]      w_remain_next;
    logic                    r_rr_last;
    logic                    w_rr_next;
    logic                    r_rej;
    logic                    w_rej_next;
    logic                    r_rd_valid;
    logic                    r_rd_id;
    logic [WORD_WIDTH-1:0]   r_rd_data;

    logic                    w_arb_win;
    logic                    w_arb_any;
    logic                    w_sel_wr;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [LEN_WIDTH-1:0]    w_sel_len;
    logic [ADDR_WIDTH:0]     w_addr_sum;
    logic [ADDR_WIDTH-1:0]   w_addr_inc;
    logic                    w_burst;
    logic                    w_last_beat;

    mem_port_arbiter_rr_arb2 u_rr_arb2 (
        .i_valid0  (i_req0_valid),
        .i_valid1  (i_req1_valid),
        .i_rr_last (r_rr_last),
        .o_win     (w_arb_win),
        .o_any     (w_arb_any)
    );

    // Winner's request fields and the following word address (wraps past the last word).
    always_comb begin
        if (w_arb_win) begin
            w_sel_wr   = i_req1_wr;
            w_sel_addr = i_req1_addr;
            w_sel_len  = i_req1_len;
        end else begin
            w_sel_wr   = i_req0_wr;
            w_sel_addr = i_req0_addr;
            w_sel_len  = i_req0_len;
        end
        w_addr_sum = {1'b0, r_cur_addr} + ADDR_STEP;
        if (w_addr_sum > LAST_WORD) begin
            w_addr_inc = ADDR_ZERO;
        end else begin
            w_addr_inc = w_addr_sum[ADDR_WIDTH-1:0];
        end
    end

    // Next-state logic: arbitrate in IDLE (not on a reject-report cycle), count beats in BURST.
    always_comb begin
        w_state_next  = r_state;
        w_win_next    = r_win;
        w_wr_next     = r_wr;
        w_addr_next   = r_cur_addr;
        w_remain_next = r_remain;
        w_rr_next     = r_rr_last;
        w_rej_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any && !r_rej) begin
                    w_win_next  = w_arb_win;
                    w_rr_next   = w_arb_win;
                    w_wr_next   = w_sel_wr;
                    w_addr_next = w_sel_addr;
                    if (w_sel_len == LEN_ZERO) begin
                        w_remain_next = MAX_BEATS;
                    end else begin
                        w_remain_next = {1'b0, w_sel_len};
                    end
                    if (w_sel_addr >= REJECT_ADDR) begin
                        w_rej_next = 1'b1;
                    end else begin
                        w_state_next = ST_BURST;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BURST: begin
                w_addr_next   = w_addr_inc;
                w_remain_next = r_remain - ONE_BEAT;
                if (r_remain == ONE_BEAT) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_BURST;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_win      <= 1'b0;
            r_wr       <= 1'b0;
            r_cur_addr <= ADDR_ZERO;
            r_remain   <= {(LEN_WIDTH + 1){1'b0}};
            r_rr_last  <= 1'b1;
            r_rej      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_win      <= w_win_next;
            r_wr       <= w_wr_next;
            r_cur_addr <= w_addr_next;
            r_remain   <= w_remain_next;
            r_rr_last  <= w_rr_next;
            r_rej      <= w_rej_next;
        end
    end

    // Read return path: capture the word addressed by each read beat.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_id    <= 1'b0;
            r_rd_data  <= WORD_ZERO;
        end else if (w_burst && !r_wr) begin
            r_rd_valid <= 1'b1;
            r_rd_id    <= r_win;
            r_rd_data  <= i_mem_data_out;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign w_burst     = (r_state == ST_BURST);
    assign w_last_beat = w_burst && (r_remain == ONE_BEAT);

    assign o_req0_grant = w_burst && !r_win;
    assign o_req0_beat  = w_burst && !r_win;
    assign o_req0_done  = (w_last_beat && !r_win) || (r_rej && !r_win);
    assign o_req0_err   = r_rej && !r_win;
    assign o_req1_grant = w_burst && r_win;
    assign o_req1_beat  = w_burst && r_win;
    assign o_req1_done  = (w_last_beat && r_win) || (r_rej && r_win);
    assign o_req1_err   = r_rej && r_win;

    // A write never commits on an edge where reset is sampled.
    assign o_mem_wr_en   = w_burst && r_wr && !i_reset;
    assign o_mem_address = w_burst ? r_cur_addr : ADDR_ZERO;
    assign o_mem_data_in = w_burst ? (r_win ? i_req1_wdata : i_req0_wdata) : WORD_ZERO;

    assign o_rd_valid = r_rd_valid;
    assign o_rd_id    = r_rd_id;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level
// model: byte array memory, last-winner round robin, fixed beat timing.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_wr, req1_valid, req1_wr;
    logic [15:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic [3:0]  req0_len, req1_len;
    logic        req0_grant, req0_beat, req0_done, req0_err;
    logic        req1_grant, req1_beat, req1_done, req1_err;
    logic        rd_valid, rd_id, mem_wr_en;
    logic [15:0] rd_data, mem_address, mem_data_in, mem_data_out;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        mem_init;

    int          checks;
    int          errors;
    int          last_served;
    logic        pend_valid;
    logic        pend_id;
    logic [15:0] pend_data;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .i_clock(clock), .i_reset(reset),
        .i_req0_valid(req0_valid), .i_req0_wr(req0_wr), .i_req0_addr(req0_addr),
        .i_req0_len(req0_len), .i_req0_wdata(req0_wdata),
        .o_req0_grant(req0_grant), .o_req0_beat(req0_beat), .o_req0_done(req0_done), .o_req0_err(req0_err),
        .i_req1_valid(req1_valid), .i_req1_wr(req1_wr), .i_req1_addr(req1_addr),
        .i_req1_len(req1_len), .i_req1_wdata(req1_wdata),
        .o_req1_grant(req1_grant), .o_req1_beat(req1_beat), .o_req1_done(req1_done), .o_req1_err(req1_err),
        .o_rd_valid(rd_valid), .o_rd_id(rd_id), .o_rd_data(rd_data),
        .o_mem_address(mem_address), .o_mem_wr_en(mem_wr_en), .o_mem_data_in(mem_data_in),
        .i_mem_data_out(mem_data_out)
    );

    assign mem_data_out = {mem[mem_address[9:0]], mem[mem_address[9:0] + 10'd1]};

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (mem_wr_en) begin
            mem[mem_address[9:0]]         <= mem_data_in[15:8];
            mem[mem_address[9:0] + 10'd1] <= mem_data_in[7:0];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] flags(input int id);
        if (id == 0) return {req0_grant, req0_beat, req0_done, req0_err};
        else return {req1_grant, req1_beat, req1_done, req1_err};
    endfunction

    task automatic set_req(input int id, input logic v, input logic wr, input logic [15:0] addr, input logic [3:0] len);
        if (id == 0) begin
            req0_valid = v; req0_wr = wr; req0_addr = addr; req0_len = len;
        end else begin
            req1_valid = v; req1_wr = wr; req1_addr = addr; req1_len = len;
        end
    endtask

    task automatic set_wdata(input int id, input logic [15:0] wd);
        if (id == 0) req0_wdata = wd;
        else req1_wdata = wd;
    endtask

    task automatic set_valid(input int id, input logic v);
        if (id == 0) req0_valid = v;
        else req1_valid = v;
    endtask

    task automatic check_rd(input string tag);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(pend_valid));
        if (pend_valid) begin
            chk({tag, "_rd_id"}, 32'(rd_id), 32'(pend_id));
            chk({tag, "_rd_data"}, 32'(rd_data), 32'(pend_data));
        end
    endtask

    // Called at the arbitration cycle; returns after sampling the last beat or the reject report.
    task automatic serve(input int id, input logic wr, input logic [15:0] addr, input logic [3:0] len, input logic [15:0] seed);
        int n;
        int a;
        logic [15:0] wd;
        n = (len == 4'd0) ? 16 : int'(len);
        set_req(id, 1'b1, wr, addr, len);
        last_served = id;
        #2;
        check_rd("arb");
        pend_valid = 1'b0;
        chk("arb_quiet", 32'({flags(0), flags(1), mem_wr_en}), 32'd0);
        chk("arb_idle_bus", {mem_address, mem_data_in}, 32'd0);
        if (int'(addr) >= MEM_DEPTH - 1) begin
            tick;
            #2;
            check_rd("rej");
            chk("rej_flags", 32'({flags(id), mem_wr_en}), 32'({4'b0011, 1'b0}));
            chk("rej_other", 32'(flags(1 - id)), 32'd0);
        end else begin
            a = int'(addr);
            for (int b = 0; b < n; b++) begin
                tick;
                wd = seed + 16'(b) * 16'h2222;
                set_wdata(id, wd);
                #2;
                check_rd("beat");
                chk("beat_own", 32'(flags(id)), 32'({2'b11, (b == n - 1), 1'b0}));
                chk("beat_other", 32'(flags(1 - id)), 32'd0);
                chk("beat_addr", 32'(mem_address), 32'(a));
                chk("beat_wr", {15'd0, mem_wr_en, mem_data_in}, {15'd0, wr, wd});
                if (wr) begin
                    ref_mem[a]     = wd[15:8];
                    ref_mem[a + 1] = wd[7:0];
                    pend_valid     = 1'b0;
                end else begin
                    pend_valid = 1'b1;
                    pend_id    = (id == 1);
                    pend_data  = {ref_mem[a], ref_mem[a + 1]};
                end
                a = (a + 2 > MEM_DEPTH - 2) ? 0 : a + 2;
            end
        end
    endtask

    task automatic finish_req(input int id);
        tick;
        set_valid(id, 1'b0);
    endtask

    task automatic idle_check;
        #2;
        check_rd("idle");
        pend_valid = 1'b0;
        chk("idle_flags", 32'({flags(0), flags(1), mem_wr_en}), 32'd0);
        chk("idle_bus", {mem_address, mem_data_in}, 32'd0);
    endtask

    task automatic solo(input int id, input logic wr, input logic [15:0] addr, input logic [3:0] len, input logic [15:0] seed);
        tick;
        serve(id, wr, addr, len, seed);
        finish_req(id);
        idle_check();
    endtask

    task automatic contend(input logic [1:0] wrs, input logic [31:0] addrs, input logic [7:0] lens, input logic [31:0] seeds);
        int w;
        int l;
        w = (last_served == 0) ? 1 : 0;
        l = 1 - w;
        tick;
        set_req(l, 1'b1, wrs[l], addrs[l*16 +: 16], lens[l*4 +: 4]);
        serve(w, wrs[w], addrs[w*16 +: 16], lens[w*4 +: 4], seeds[w*16 +: 16]);
        finish_req(w);
        serve(l, wrs[l], addrs[l*16 +: 16], lens[l*4 +: 4], seeds[l*16 +: 16]);
        finish_req(l);
        idle_check();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        #2;
        chk("rst_flags", 32'({flags(0), flags(1), mem_wr_en, rd_valid}), 32'd0);
        chk("rst_bus", {mem_address, mem_data_in}, 32'd0);
        tick;
        reset = 1'b0;
        last_served = 1;
        pend_valid  = 1'b0;
        idle_check();
    endtask

    initial begin
        logic [15:0] ra [2];
        logic [3:0]  rl [2];
        logic [1:0]  rw;
        logic [15:0] rs [2];
        checks = 0; errors = 0; last_served = 1; pend_valid = 1'b0; pend_id = 1'b0; pend_data = 16'h0;
        reset = 1'b1; mem_init = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'h0, 4'h0); set_req(1, 1'b0, 1'b0, 16'h0, 4'h0);
        req0_wdata = 16'h0; req1_wdata = 16'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
        tick;
        mem_init = 1'b0;
        do_reset();

        solo(0, 1'b1, 16'h0010, 4'd2, 16'hA1B2);
        chk("t1_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hA1B2C3D4);
        solo(1, 1'b0, 16'h0010, 4'd2, 16'h0000);

        do_reset();
        contend(2'b11, {16'h0100, 16'h0200}, {4'd1, 4'd1}, {16'h1111, 16'h5555});
        contend(2'b00, {16'h0100, 16'h0200}, {4'd1, 4'd1}, {16'h0000, 16'h0000});

        solo(0, 1'b0, 16'd1020, 4'd3, 16'h0000);
        solo(0, 1'b1, 16'd1021, 4'd3, 16'h7E01);
        solo(1, 1'b1, 16'd1023, 4'd2, 16'hDEAD);
        solo(0, 1'b1, 16'h0030, 4'd0, 16'h0F0F);

        tick;
        set_req(0, 1'b1, 1'b1, 16'h0040, 4'd4);
        last_served = 0;
        #2;
        check_rd("r6_arb");
        pend_valid = 1'b0;
        tick;
        set_wdata(0, 16'h1357);
        #2;
        chk("r6_beat1", {mem_address, 15'd0, mem_wr_en}, {16'h0040, 15'd0, 1'b1});
        ref_mem[64] = 8'h13; ref_mem[65] = 8'h57;
        tick;
        set_wdata(0, 16'h2468);
        reset = 1'b1;
        #2;
        chk("r6_no_write", 32'(mem_wr_en), 32'd0);
        tick;
        reset = 1'b0;
        set_valid(0, 1'b0);
        last_served = 1;
        idle_check();
        chk("r6_rd_data", 32'(rd_data), 32'd0);

        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 2; j++) begin
                ra[j] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1023, 65535)) : 16'($urandom_range(0, 1022));
                rl[j] = 4'($urandom_range(0, 15));
                rw[j] = 1'($urandom_range(0, 1));
                rs[j] = 16'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                contend(rw, {ra[1], ra[0]}, {rl[1], rl[0]}, {rs[1], rs[0]});
            end else begin
                solo(k % 2, rw[0], ra[0], rl[0], rs[0]);
            end
        end

        for (int i = 0; i < 1024; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
